// File: rtl/tm1638_responder.sv
// Device end of a TM1638-style STB/CLK/DIO link: decodes command/data frames,
// holds the 16-byte display RAM and display control, and shifts key-scan data out.
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         rst,
  input  logic         i_ledkey_clk,
  input  logic         i_ledkey_stb,
  input  logic         i_dio,
  output logic         o_dio,
  output logic         o_dio_oe,
  input  logic [7:0]   i_keys,
  output logic [127:0] o_display_ram,
  output logic         o_display_on,
  output logic [2:0]   o_brightness,
  output logic         o_cmd_strobe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ,
    S_DISCARD
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync, stb_sync, dio_sync;
  logic clk_d, stb_d;
  logic clk_s, stb_s, dio_s;

  logic [2:0]  bit_cnt;
  logic [6:0]  shift_q;
  logic [3:0]  ptr;
  logic        read_mode;
  logic        fixed_addr;
  logic [7:0]  ram [16];
  logic [31:0] key_resp;
  logic [31:0] key_image;
  logic [5:0]  resp_cnt;

  logic stb_fall, stb_rise, clk_rise, clk_fall;
  logic byte_done;
  logic [7:0] byte_val;

  // Pins idle high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      stb_sync <= '1;
      dio_sync <= '1;
      clk_d    <= 1'b1;
      stb_d    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_ledkey_clk};
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], i_ledkey_stb};
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], i_dio};
      clk_d    <= clk_sync[SYNC_STAGES-1];
      stb_d    <= stb_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign stb_s = stb_sync[SYNC_STAGES-1];
  assign dio_s = dio_sync[SYNC_STAGES-1];

  assign stb_fall = stb_d & ~stb_s;
  assign stb_rise = ~stb_d & stb_s;
  // CLK edges count only while STB has been low for both samples.
  assign clk_rise = ~clk_d & clk_s & ~stb_s & ~stb_d;
  assign clk_fall = clk_d & ~clk_s & ~stb_s & ~stb_d;

  assign byte_val  = {dio_s, shift_q};
  assign byte_done = clk_rise && (bit_cnt == 3'd7) &&
                     (state_q != S_IDLE) && (state_q != S_READ);

  always_comb begin
    key_image = '0;
    for (int n = 0; n < 4; n++) begin
      key_image[8*n]     = i_keys[n];
      key_image[8*n + 4] = i_keys[n + 4];
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path through always_comb leaves state_d unassigned (no latch).
    state_d = state_q;
    if (stb_rise) begin
      state_d = S_IDLE;
    end else if (stb_fall) begin
      state_d = S_CMD;
    end else if (state_q == S_CMD && byte_done) begin
      unique case (byte_val[7:6])
        2'b01:   state_d = byte_val[1] ? S_READ : S_DISCARD;
        2'b11:   state_d = S_WRITE;
        default: state_d = S_DISCARD;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      bit_cnt      <= '0;
      shift_q      <= '0;
      ptr          <= '0;
      read_mode    <= 1'b0;
      fixed_addr   <= 1'b0;
      key_resp     <= '0;
      resp_cnt     <= '0;
      o_display_on <= 1'b0;
      o_brightness <= '0;
      o_cmd_strobe <= 1'b0;
      o_dio        <= 1'b1;
      o_dio_oe     <= 1'b0;
      // NOTE: the display RAM is a visible output with a defined reset value, so it is built from resettable flops.
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else begin
      o_cmd_strobe <= 1'b0;
      if (stb_rise) begin
        bit_cnt  <= '0;
        o_dio    <= 1'b1;
        o_dio_oe <= 1'b0;
      end else if (stb_fall) begin
        bit_cnt <= '0;
        shift_q <= '0;
      end else begin
        if (clk_rise && state_q != S_IDLE && state_q != S_READ) begin
          bit_cnt <= bit_cnt + 3'd1;
          shift_q <= {dio_s, shift_q[6:1]};
        end

        if (byte_done && state_q == S_CMD) begin
          o_cmd_strobe <= 1'b1;
          unique case (byte_val[7:6])
            2'b01: begin
              read_mode  <= byte_val[1];
              fixed_addr <= byte_val[2];
              key_resp   <= key_image;
              resp_cnt   <= '0;
            end
            2'b10: begin
              o_display_on <= byte_val[3];
              o_brightness <= byte_val[2:0];
            end
            2'b11:   ptr <= byte_val[3:0];
            default: ;
          endcase
        end

        if (byte_done && state_q == S_WRITE && !read_mode) begin
          ram[ptr] <= byte_val;
          if (!fixed_addr) ptr <= ptr + 4'd1;
        end

        // After the 32 response bits the line is held low until the frame closes.
        if (clk_fall && state_q == S_READ) begin
          o_dio_oe <= 1'b1;
          if (resp_cnt[5]) begin
            o_dio <= 1'b0;
          end else begin
            o_dio    <= key_resp[resp_cnt[4:0]];
            resp_cnt <= resp_cnt + 6'd1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign o_display_ram[8*g +: 8] = ram[g];
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// Drives controller-side frames into tm1638_responder and checks RAM, display
// control, command strobes and the key-scan response against a bench model.
module tb_tm1638_responder;

  localparam int HALF = 6;

  logic         i_clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_ledkey_clk = 1'b1;
  logic         i_ledkey_stb = 1'b1;
  logic         i_dio = 1'b1;
  logic         o_dio;
  logic         o_dio_oe;
  logic [7:0]   i_keys = '0;
  logic [127:0] o_display_ram;
  logic         o_display_on;
  logic [2:0]   o_brightness;
  logic         o_cmd_strobe;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;

  logic [7:0] model_ram [16];
  logic [7:0] tx [$];
  logic [7:0] sb [$];

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .i_clk         (i_clk),
    .rst           (rst),
    .i_ledkey_clk  (i_ledkey_clk),
    .i_ledkey_stb  (i_ledkey_stb),
    .i_dio         (i_dio),
    .o_dio         (o_dio),
    .o_dio_oe      (o_dio_oe),
    .i_keys        (i_keys),
    .o_display_ram (o_display_ram),
    .o_display_on  (o_display_on),
    .o_brightness  (o_brightness),
    .o_cmd_strobe  (o_cmd_strobe)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_cmd_strobe === 1'b1) strobe_cnt++;

  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = model_ram[i];
    return v;
  endfunction

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      i_ledkey_clk = 1'b0;
      i_dio = b[i];
      cycles(HALF);
      i_ledkey_clk = 1'b1;
      cycles(HALF);
    end
  endtask

  task automatic stb_open();
    i_ledkey_stb = 1'b0;
    cycles(HALF);
  endtask

  task automatic stb_close();
    i_ledkey_stb = 1'b1;
    i_dio = 1'b1;
    cycles(HALF + 2);
  endtask

  task automatic send_frame();
    stb_open();
    foreach (tx[i]) send_bits(tx[i], 8);
    stb_close();
    tx.delete();
  endtask

  // Clocks one response byte out, comparing each bit and the enable.
  task automatic read_byte(input string name);
    logic [7:0] got, exp;
    logic oe_ok;
    oe_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_ledkey_clk = 1'b0;
      cycles(HALF);
      @(negedge i_clk);
      got[i] = o_dio;
      if (o_dio_oe !== 1'b1) oe_ok = 1'b0;
      #1;
      i_ledkey_clk = 1'b1;
      cycles(HALF);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
    total++;
    if (oe_ok !== 1'b1) begin
      bad++;
      $display("FAIL %s_oe: o_dio_oe dropped during response", name);
    end
  endtask

  task automatic push_keys(input logic [7:0] k);
    for (int n = 0; n < 4; n++) sb.push_back({3'b000, k[n + 4], 3'b000, k[n]});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    @(negedge i_clk);
    total++;
    if ({o_display_ram, o_display_on, o_brightness, o_dio, o_dio_oe, o_cmd_strobe} !==
        {128'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: ram=%032h on=%b br=%0d dio=%b oe=%b stb=%b", o_display_ram,
               o_display_on, o_brightness, o_dio, o_dio_oe, o_cmd_strobe);
    end
    #1;
    rst = 1'b0;
    cycles(4);
    for (int i = 0; i < 16; i++) model_ram[i] = '0;
  endtask

  task automatic test_write_auto();
    logic [7:0] digits [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    int s0;
    s0 = strobe_cnt;
    tx.push_back(8'h40); send_frame();
    tx.push_back(8'hC0);
    for (int i = 0; i < 16; i++) begin
      tx.push_back(digits[i]);
      model_ram[i] = digits[i];
    end
    send_frame();
    tx.push_back(8'h8F); send_frame();
    total++;
    if (o_display_ram !== model_vec()) begin
      bad++;
      $display("FAIL write_auto_ram: got %032h expected %032h", o_display_ram, model_vec());
    end
    total++;
    if ({o_display_on, o_brightness} !== {1'b1, 3'd7}) begin
      bad++;
      $display("FAIL write_auto_ctrl: on=%b br=%0d expected on=1 br=7", o_display_on, o_brightness);
    end
    total++;
    if (strobe_cnt - s0 !== 3) begin
      bad++;
      $display("FAIL write_auto_strobes: got %0d expected 3", strobe_cnt - s0);
    end
  endtask

  task automatic test_fixed();
    int s0;
    s0 = strobe_cnt;
    tx.push_back(8'h44); send_frame();
    tx.push_back(8'hC5); tx.push_back(8'hAA); tx.push_back(8'h55); send_frame();
    model_ram[5] = 8'h55;
    total++;
    if (o_display_ram !== model_vec()) begin
      bad++;
      $display("FAIL fixed_addr: got %032h expected %032h", o_display_ram, model_vec());
    end
    total++;
    if (strobe_cnt - s0 !== 2) begin
      bad++;
      $display("FAIL fixed_strobes: got %0d expected 2", strobe_cnt - s0);
    end
  endtask

  task automatic test_wrap();
    tx.push_back(8'h40); send_frame();
    tx.push_back(8'hCF); tx.push_back(8'h11); tx.push_back(8'h22); send_frame();
    model_ram[15] = 8'h11;
    model_ram[0]  = 8'h22;
    total++;
    if (o_display_ram !== model_vec()) begin
      bad++;
      $display("FAIL wrap: got %032h expected %032h", o_display_ram, model_vec());
    end
  endtask

  task automatic read_frame(input logic [7:0] keys, input string name);
    i_keys = keys;
    push_keys(keys);
    stb_open();
    send_bits(8'h42, 8);
    for (int b = 0; b < 4; b++) read_byte(name);
    i_ledkey_clk = 1'b0;
    cycles(HALF);
    total++;
    if ({o_dio_oe, o_dio} !== 2'b10) begin
      bad++;
      $display("FAIL %s_tail: oe=%b dio=%b expected oe=1 dio=0", name, o_dio_oe, o_dio);
    end
    i_ledkey_clk = 1'b1;
    cycles(HALF);
    stb_close();
    total++;
    if ({o_dio_oe, o_dio} !== 2'b01) begin
      bad++;
      $display("FAIL %s_release: oe=%b dio=%b expected oe=0 dio=1", name, o_dio_oe, o_dio);
    end
  endtask

  task automatic test_read_keys();
    read_frame(8'b1000_0101, "read_keys");
    read_frame(8'($urandom), "read_keys_rand");
    total++;
    if (o_display_ram !== model_vec()) begin
      bad++;
      $display("FAIL read_no_store: got %032h expected %032h", o_display_ram, model_vec());
    end
  endtask

  task automatic test_partial();
    tx.push_back(8'h40); send_frame();
    stb_open();
    send_bits(8'hC3, 8);
    send_bits(8'hEE, 5);
    stb_close();
    total++;
    if (o_display_ram !== model_vec()) begin
      bad++;
      $display("FAIL partial_discard: got %032h expected %032h", o_display_ram, model_vec());
    end
    tx.push_back(8'hC3); tx.push_back(8'h99); send_frame();
    model_ram[3] = 8'h99;
    total++;
    if (o_display_ram !== model_vec()) begin
      bad++;
      $display("FAIL partial_next: got %032h expected %032h", o_display_ram, model_vec());
    end
  endtask

  task automatic test_reset_mid();
    i_keys = 8'h5A;
    push_keys(8'h5A);
    stb_open();
    send_bits(8'h42, 8);
    read_byte("reset_mid_read");
    i_ledkey_clk = 1'b0;
    cycles(HALF);
    rst = 1'b1;
    #2;
    total++;
    if ({o_display_ram, o_display_on, o_brightness, o_dio, o_dio_oe, o_cmd_strobe} !==
        {128'h0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid: ram=%032h on=%b br=%0d dio=%b oe=%b stb=%b", o_display_ram,
               o_display_on, o_brightness, o_dio, o_dio_oe, o_cmd_strobe);
    end
    sb.delete();
    for (int i = 0; i < 16; i++) model_ram[i] = '0;
    i_ledkey_clk = 1'b1;
    i_ledkey_stb = 1'b1;
    i_dio = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(HALF);
    tx.push_back(8'h40); send_frame();
    tx.push_back(8'hC2); tx.push_back(8'h5A); send_frame();
    tx.push_back(8'h88); send_frame();
    model_ram[2] = 8'h5A;
    total++;
    if (o_display_ram !== model_vec()) begin
      bad++;
      $display("FAIL reset_recover_ram: got %032h expected %032h", o_display_ram, model_vec());
    end
    total++;
    if ({o_display_on, o_brightness} !== {1'b1, 3'd0}) begin
      bad++;
      $display("FAIL reset_recover_ctrl: on=%b br=%0d expected on=1 br=0", o_display_on, o_brightness);
    end
  endtask

  initial begin
    test_reset();
    test_write_auto();
    test_fixed();
    test_wrap();
    test_read_keys();
    test_partial();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
